// File: rtl/rr_lane_arbiter.sv
// rr_lane_arbiter: round-robin arbiter that loads one requester word per cycle into a single lane output register.
// Latency: 1 cycle from accept (req_valid && req_ready) to out_valid.
// Backpressure: while out_valid && !out_ready the register, source and pointer hold and req_ready is all-zero.
// Ports: clk, rst (synchronous, active-high); req_valid/req_data/req_ready, one slot per requester;
//        out_valid/out_data/out_src/out_ready toward the single downstream consumer.
// Optional: define RR_GRANT_CNT_EN to add grant_cnt, one saturating 8-bit accept counter per requester.
module rr_lane_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = 4,
   localparam int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic [SRC_W-1:0]          out_src,
`ifdef RR_GRANT_CNT_EN
   output logic [NUM_REQ*8-1:0]      grant_cnt,
`endif
   input  logic                      out_ready
);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [SRC_W-1:0]  out_src_q, out_src_d;
   logic [SRC_W-1:0]  ptr_q, ptr_d;
   logic              load_en;
   logic              win_vld;
   logic [SRC_W-1:0]  win_idx;
   logic [SRC_W:0]    scan_idx;
   logic [DATA_W-1:0] win_data;
   logic              accept;

   // The register may be refilled whenever it is empty or being drained this cycle.
   assign load_en = !out_valid_q || out_ready;
   assign accept  = load_en && win_vld && !rst;

   // Scan from ptr upward with wrap; one spare bit keeps ptr+k from overflowing
   // before the modulo fold, which also covers non-power-of-two NUM_REQ.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, ptr_q} + (SRC_W+1)'(k);
         if (scan_idx >= (SRC_W+1)'(NUM_REQ)) begin
            scan_idx = scan_idx - (SRC_W+1)'(NUM_REQ);
         end
         if (!win_vld && req_valid[scan_idx[SRC_W-1:0]]) begin
            win_vld = 1'b1;
            win_idx = scan_idx[SRC_W-1:0];
         end
      end
   end

   // Grant decode and word select; req_ready is a function of valid/state only, never of data.
   always_comb begin
      req_ready = '0;
      win_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == SRC_W'(i)) begin
            win_data     = req_data[i*DATA_W +: DATA_W];
            req_ready[i] = win_vld && load_en && !rst;
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      ptr_d       = ptr_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = win_data;
         out_src_d   = win_idx;
         ptr_d       = (win_idx == SRC_W'(NUM_REQ-1)) ? '0 : win_idx + SRC_W'(1);
      end else if (out_ready) begin
         // Drained with nothing to refill: data and source keep their last values.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_src_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_src_q   <= out_src_d;
         ptr_q       <= ptr_d;
      end
   end

   for (genvar b = 0; b < DATA_W; b++) begin : g_out_bit
      always_ff @(posedge clk) begin
         if (rst) begin
            out_data_q[b] <= 1'b0;
         end else begin
            out_data_q[b] <= out_data_d[b];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

`ifdef RR_GRANT_CNT_EN
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
      logic [7:0] cnt_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q <= '0;
         end else if (accept && (win_idx == SRC_W'(i)) && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
      assign grant_cnt[i*8 +: 8] = cnt_q;
   end
`endif

endmodule

// File: tb/tb_rr_lane_arbiter.sv
// tb_rr_lane_arbiter: directed bench for rr_lane_arbiter (NUM_REQ=4, DATA_W=4).
// Inputs change at the falling edge; outputs are compared at the falling edge (plus 1 ns after input changes).
// Expected values are hand-derived constants per step.
module tb_rr_lane_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic [3:0]  out_data;
   logic [1:0]  out_src;
   logic        out_ready;
`ifdef RR_GRANT_CNT_EN
   logic [31:0] grant_cnt;
`endif

   int n_chk;
   int n_bad;

   rr_lane_arbiter #(.NUM_REQ(4), .DATA_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
`ifdef RR_GRANT_CNT_EN
      .grant_cnt (grant_cnt),
`endif
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One rising edge, then settle at the following falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] s);
      chk({tag, "_vld"}, 32'(out_valid), 32'(v));
      chk({tag, "_dat"}, 32'(out_data), 32'(d));
      chk({tag, "_src"}, 32'(out_src), 32'(s));
   endtask

   initial begin
      n_chk     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      req_valid = 4'b1111;
      req_data  = 16'h4321;
      out_ready = 1'b1;

      // Reset held two cycles with every requester valid.
      cyc();
      chk("rst1_rdy", 32'(req_ready), 32'h0);
      chk_out("rst1", 1'b0, 4'h0, 2'd0);
      cyc();
      chk("rst2_rdy", 32'(req_ready), 32'h0);
      chk_out("rst2", 1'b0, 4'h0, 2'd0);
      rst = 1'b0;
      #1;
      chk("first_rdy", 32'(req_ready), 32'b0001);

      // Round-robin across four always-valid requesters at full throughput.
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk_out($sformatf("rr%0d", k), 1'b1, 4'((k % 4) + 1), 2'(k % 4));
         chk($sformatf("rr%0d_rdy", k), 32'(req_ready), 32'(1 << ((k + 1) % 4)));
      end

      // Backpressure: load 0xA from requester 1 (ptr is 1), then stall three cycles.
      req_valid = 4'b0010;
      req_data  = 16'h00A0;
      cyc();
      chk_out("bp_load", 1'b1, 4'hA, 2'd1);
      req_valid = 4'b0100;
      req_data  = 16'h0500;
      out_ready = 1'b0;
      #1;
      chk("bp_rdy0", 32'(req_ready), 32'h0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk_out($sformatf("bp_hold%0d", k), 1'b1, 4'hA, 2'd1);
         chk($sformatf("bp_hold%0d_rdy", k), 32'(req_ready), 32'h0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", 32'(req_ready), 32'b0100);
      cyc();
      chk_out("bp_swap", 1'b1, 4'h5, 2'd2);

      // Skip and wrap: ptr is 3, requesters 0 and 2 valid.
      req_valid = 4'b0101;
      req_data  = 16'h0907;
      #1;
      chk("sw_rdy0", 32'(req_ready), 32'b0001);
      cyc();
      chk_out("sw0", 1'b1, 4'h7, 2'd0);
      chk("sw0_rdy", 32'(req_ready), 32'b0100);
      cyc();
      chk_out("sw1", 1'b1, 4'h9, 2'd2);
      chk("sw1_rdy", 32'(req_ready), 32'b0001);
      cyc();
      chk_out("sw2", 1'b1, 4'h7, 2'd0);

      // Drain with no requester: valid drops, data/src hold, ptr (1) does not move while idle.
      req_valid = 4'b0000;
      cyc();
      chk_out("drain", 1'b0, 4'h7, 2'd0);
      chk("drain_rdy", 32'(req_ready), 32'h0);
      cyc();
      chk_out("idle", 1'b0, 4'h7, 2'd0);
      req_valid = 4'b1111;
      req_data  = 16'h4321;
      #1;
      chk("idle_ptr_rdy", 32'(req_ready), 32'b0010);
      cyc();
      chk_out("pre_rst", 1'b1, 4'h2, 2'd1);

      // Reset while stalled: word dropped, no ready pulse, pointer back to 0.
      out_ready = 1'b0;
      rst       = 1'b1;
      #1;
      chk("mid_rst_rdy", 32'(req_ready), 32'h0);
      cyc();
      chk_out("mid_rst", 1'b0, 4'h0, 2'd0);
      chk("mid_rst_rdy2", 32'(req_ready), 32'h0);
      rst = 1'b0;
      #1;
      chk("post_rst_rdy", 32'(req_ready), 32'b0001);

`ifdef RR_GRANT_CNT_EN
      // Requester 1 alone, accepted 300 times: its counter saturates, others stay 0.
      req_valid = 4'b0010;
      out_ready = 1'b1;
      #1;
      chk("cnt_start", grant_cnt, 32'h0);
      for (int k = 0; k < 300; k++) begin
         cyc();
      end
      chk("cnt_sat", grant_cnt, 32'h0000_FF00);
      rst = 1'b1;
      cyc();
      chk("cnt_rst", grant_cnt, 32'h0);
      rst = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
